bus_arbiter_rr: RTL and testbench

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arbiter_rr.sv | 188 ++++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
//------------------------------------------------------------------------------
// bus_arbiter_rr : round-robin bus arbiter with GRANT/ADDR handshake timeouts
//                  and sticky error flags. Optional macro: ARB_INPUT_SYNC_EN.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bus_arbiter_rr #(
  parameter int DeviceMaxNumber = 4,
  parameter int TimeoutCycles   = 16
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [DeviceMaxNumber-1:0] BARQ,
  output logic [DeviceMaxNumber-1:0] BAGD,
  input  logic                       AddressValid,
  input  logic                       TargetReady,
  input  logic                       DataStrobe,
  output logic [2:0]                 Error
);

  localparam int OwnerW = (DeviceMaxNumber > 1) ? $clog2(DeviceMaxNumber) : 1;
  localparam int CntW   = $clog2(TimeoutCycles + 1);
  localparam int InW    = DeviceMaxNumber + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ADDR  = 2'd2,
    DATA  = 2'd3
  } state_t;

  logic [DeviceMaxNumber-1:0] barq_e;
  logic                       av_e;
  logic                       tr_e;
  logic                       ds_e;

`ifdef ARB_INPUT_SYNC_EN
  logic [InW-1:0] sync1_d, sync1_q;
  logic [InW-1:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = {BARQ, AddressValid, TargetReady, DataStrobe};
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign {barq_e, av_e, tr_e, ds_e} = sync2_q;
`else
  logic [InW-1:0] raw_in;
  assign raw_in                     = {BARQ, AddressValid, TargetReady, DataStrobe};
  assign {barq_e, av_e, tr_e, ds_e} = raw_in;
`endif

  state_t                     state_d, state_q;
  logic [DeviceMaxNumber-1:0] bagd_d, bagd_q;
  logic [2:0]                 error_d, error_q;
  logic [CntW-1:0]            cnt_d, cnt_q;
  logic [OwnerW-1:0]          last_owner_d, last_owner_q;

  logic [OwnerW:0]            rr_sum;
  logic [OwnerW-1:0]          rr_idx;
  logic                       rr_found;
  logic [OwnerW-1:0]          winner;
  logic [DeviceMaxNumber-1:0] winner_oh;
  logic                       owner_req;
  logic                       grant_clear;
  logic [2:0]                 err_set;

  // Search begins just after the previous owner and wraps modulo the device count.
  always_comb begin
    rr_sum   = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    winner   = last_owner_q;
    for (int i = 1; i <= DeviceMaxNumber; i++) begin
      rr_sum = {1'b0, last_owner_q} + (OwnerW+1)'(i);
      if (rr_sum >= (OwnerW+1)'(DeviceMaxNumber)) begin
        rr_sum = rr_sum - (OwnerW+1)'(DeviceMaxNumber);
      end
      rr_idx = rr_sum[OwnerW-1:0];
      if (!rr_found && barq_e[rr_idx]) begin
        rr_found = 1'b1;
        winner   = rr_idx;
      end
    end
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
  end

  assign owner_req = barq_e[last_owner_q];

  always_comb begin
    state_d      = state_q;
    bagd_d       = bagd_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    grant_clear  = 1'b0;
    err_set      = 3'b000;
    err_set[2]   = ds_e && (state_q != DATA);

    case (state_q)
      IDLE: begin
        if (|barq_e) begin
          state_d      = GRANT;
          bagd_d       = winner_oh;
          last_owner_d = winner;
          cnt_d        = '0;
          grant_clear  = 1'b1;
        end
      end
      // A dropped request beats a same-cycle handshake; a handshake beats a same-cycle timeout.
      GRANT: begin
        if (!owner_req) begin
          state_d = IDLE;
          bagd_d  = '0;
        end else if (av_e) begin
          state_d = ADDR;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          state_d    = IDLE;
          bagd_d     = '0;
          err_set[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ADDR: begin
        if (!owner_req) begin
          state_d = IDLE;
          bagd_d  = '0;
        end else if (tr_e) begin
          state_d = DATA;
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          state_d    = IDLE;
          bagd_d     = '0;
          err_set[1] = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (!owner_req) begin
          state_d = IDLE;
          bagd_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        bagd_d  = '0;
      end
    endcase

    // New error events override the clear that accompanies a fresh grant.
    error_d = (grant_clear ? 3'b000 : error_q) | err_set;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      bagd_q       <= '0;
      error_q      <= 3'b000;
      cnt_q        <= '0;
      last_owner_q <= OwnerW'(DeviceMaxNumber - 1);
    end else begin
      state_q      <= state_d;
      bagd_q       <= bagd_d;
      error_q      <= error_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign BAGD  = bagd_q;
  assign Error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
//------------------------------------------------------------------------------
// tb_bus_arbiter_rr : directed self-checking bench for bus_arbiter_rr (4 devices,
//                     16-cycle timeout, input synchroniser disabled).
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       Reset;
  logic [3:0] BARQ;
  logic [3:0] BAGD;
  logic       AddressValid;
  logic       TargetReady;
  logic       DataStrobe;
  logic [2:0] Error;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .DeviceMaxNumber(4),
    .TimeoutCycles  (16)
  ) u_dut (
    .clk         (clk),
    .Reset       (Reset),
    .BARQ        (BARQ),
    .BAGD        (BAGD),
    .AddressValid(AddressValid),
    .TargetReady (TargetReady),
    .DataStrobe  (DataStrobe),
    .Error       (Error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One full tenure: 1 idle GRANT cycle, AV, 1 idle ADDR cycle, TR, 2 DATA cycles, drop.
  task automatic tenure(input logic [3:0] exp_g);
    tick();
    chk_eq("rr_grant", 8'(BAGD), 8'(exp_g));
    tick();
    AddressValid = 1'b1;
    tick();
    AddressValid = 1'b0;
    tick();
    TargetReady = 1'b1;
    tick();
    TargetReady = 1'b0;
    tick();
    tick();
    chk_eq("rr_data_hold", 8'(BAGD), 8'(exp_g));
    BARQ = BARQ & ~exp_g;
    tick();
    chk_eq("rr_release", 8'(BAGD), 8'h00);
    BARQ = 4'b1111;
  endtask

  initial begin
    Reset        = 1'b0;
    BARQ         = 4'b0000;
    AddressValid = 1'b0;
    TargetReady  = 1'b0;
    DataStrobe   = 1'b0;
    tick();
    tick();
    chk_eq("reset_bagd", 8'(BAGD), 8'h00);
    chk_eq("reset_err", 8'(Error), 8'h00);
    Reset = 1'b1;
    tick();

    // Round robin over all four requesters, then wrap back to device 0.
    BARQ = 4'b1111;
    tenure(4'b0001);
    tenure(4'b0010);
    tenure(4'b0100);
    tenure(4'b1000);
    tenure(4'b0001);
    chk_eq("rr_err", 8'(Error), 8'h00);
    BARQ = 4'b0000;
    tick();

    // GRANT timeout: 16 cycles of grant, then release with Error[0].
    BARQ = 4'b0100;
    tick();
    chk_eq("to0_grant", 8'(BAGD), 8'b0100);
    repeat (15) tick();
    chk_eq("to0_cycle16", 8'(BAGD), 8'b0100);
    chk_eq("to0_err_pre", 8'(Error), 8'h00);
    tick();
    chk_eq("to0_bagd", 8'(BAGD), 8'h00);
    chk_eq("to0_err", 8'(Error), 8'b001);
    tick();
    chk_eq("to0_regrant", 8'(BAGD), 8'b0100);
    chk_eq("to0_clear", 8'(Error), 8'h00);
    BARQ = 4'b0000;
    tick();
    chk_eq("drop_grant_bagd", 8'(BAGD), 8'h00);
    chk_eq("drop_grant_err", 8'(Error), 8'h00);

    // TargetReady on the 16th ADDR cycle wins; DATA has no timeout.
    BARQ = 4'b0010;
    tick();
    chk_eq("to1_grant", 8'(BAGD), 8'b0010);
    AddressValid = 1'b1;
    tick();
    AddressValid = 1'b0;
    repeat (15) tick();
    TargetReady = 1'b1;
    tick();
    TargetReady = 1'b0;
    chk_eq("to1_edge_err", 8'(Error), 8'h00);
    repeat (20) tick();
    chk_eq("data_no_timeout", 8'(BAGD), 8'b0010);
    BARQ = 4'b0000;
    tick();
    chk_eq("data_release", 8'(BAGD), 8'h00);

    // Same stimulus one cycle late: ADDR timeout sets Error[1].
    BARQ = 4'b0010;
    tick();
    AddressValid = 1'b1;
    tick();
    AddressValid = 1'b0;
    repeat (16) tick();
    chk_eq("to1_bagd", 8'(BAGD), 8'h00);
    chk_eq("to1_err", 8'(Error), 8'b010);
    BARQ        = 4'b0000;
    TargetReady = 1'b1;
    tick();
    TargetReady = 1'b0;
    chk_eq("to1_sticky", 8'(Error), 8'b010);

    // DataStrobe outside DATA.
    BARQ = 4'b0001;
    tick();
    chk_eq("ds_pre_grant", 8'(BAGD), 8'b0001);
    chk_eq("ds_pre_clear", 8'(Error), 8'h00);
    BARQ = 4'b0000;
    tick();
    DataStrobe = 1'b1;
    tick();
    DataStrobe = 1'b0;
    chk_eq("ds_idle", 8'(Error), 8'b100);
    repeat (5) tick();
    chk_eq("ds_held", 8'(Error), 8'b100);
    BARQ = 4'b1000;
    tick();
    chk_eq("ds_grant", 8'(BAGD), 8'b1000);
    chk_eq("ds_cleared", 8'(Error), 8'h00);
    BARQ = 4'b0000;
    tick();

    // Reset during DATA releases the grant without a clock edge.
    BARQ = 4'b0010;
    tick();
    chk_eq("rst_grant", 8'(BAGD), 8'b0010);
    AddressValid = 1'b1;
    tick();
    AddressValid = 1'b0;
    TargetReady  = 1'b1;
    tick();
    TargetReady = 1'b0;
    DataStrobe  = 1'b1;
    tick();
    DataStrobe = 1'b0;
    chk_eq("ds_in_data", 8'(Error), 8'h00);
    chk_eq("rst_pre_bagd", 8'(BAGD), 8'b0010);
    #2 Reset = 1'b0;
    #1;
    chk_eq("rst_async_bagd", 8'(BAGD), 8'h00);
    chk_eq("rst_async_err", 8'(Error), 8'h00);
    tick();
    Reset = 1'b1;
    chk_eq("rst_release_bagd", 8'(BAGD), 8'h00);
    tick();
    chk_eq("rst_regrant", 8'(BAGD), 8'b0010);

    // Drop on the same cycle as AddressValid: drop wins.
    AddressValid = 1'b1;
    BARQ         = 4'b0000;
    tick();
    AddressValid = 1'b0;
    chk_eq("drop_vs_av", 8'(BAGD), 8'h00);
    chk_eq("drop_vs_av_err", 8'(Error), 8'h00);
    tick();

    // AddressValid on the 16th GRANT cycle beats the timeout.
    BARQ = 4'b0100;
    tick();
    repeat (15) tick();
    AddressValid = 1'b1;
    tick();
    AddressValid = 1'b0;
    chk_eq("av_edge_bagd", 8'(BAGD), 8'b0100);
    chk_eq("av_edge_err", 8'(Error), 8'h00);
    BARQ = 4'b0000;
    tick();

    // Error set on the grant cycle takes priority over the clear.
    BARQ       = 4'b0001;
    DataStrobe = 1'b1;
    tick();
    DataStrobe = 1'b0;
    chk_eq("prio_grant", 8'(BAGD), 8'b0001);
    chk_eq("prio_err", 8'(Error), 8'b100);
    BARQ = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
